// File: rtl/rng_pkg.sv
// Shared constants for the ring-oscillator TRNG post-processor: FSM encodings,
// generator defaults and health-test thresholds.
package rng_pkg;

  localparam logic [1:0] ST_SEED = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FAIL = 2'd2;

  localparam int              LFSR_W_DEF    = 43;
  localparam logic [42:0]     LFSR_TAPS_DEF = 43'h630_0000_0000;
  localparam int              CASR_W_DEF    = 37;
  localparam int              CASR_150_DEF  = 28;
  localparam int              WORD_W_DEF    = 32;
  localparam int              INIT_BITS_DEF = 80;

  localparam int RCT_CUTOFF_DEF = 32;
  localparam int APT_WIN_DEF    = 512;
  localparam int APT_CUTOFF_DEF = 410;

endpackage

// File: rtl/rng_hlth.sv
// Continuous health tests on a raw entropy stream: repetition-count and
// adaptive-proportion counters with sticky failure flags.
module rng_hlth
  import rng_pkg::*;
#(
  parameter int RCT_CUTOFF = RCT_CUTOFF_DEF,
  parameter int APT_WIN    = APT_WIN_DEF,
  parameter int APT_CUTOFF = APT_CUTOFF_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample,
  input  logic sample_valid,
  input  logic clr,
  output logic rct_fail,
  output logic apt_fail,
  output logic fail_evt
);

  localparam int RCT_CW = $clog2(RCT_CUTOFF + 1);
  localparam int APT_WW = $clog2(APT_WIN);
  localparam int APT_CW = $clog2(APT_WIN + 1);

  logic [RCT_CW-1:0] rct_cnt, rct_nxt;
  logic              last_bit;
  logic [APT_WW-1:0] win_cnt;
  logic              ref_bit;
  logic [APT_CW-1:0] apt_cnt, apt_nxt;
  logic              rct_hit, apt_hit;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rct_nxt = rct_cnt;
    if (rct_cnt == '0 || sample != last_bit)
      rct_nxt = RCT_CW'(1);
    else if (rct_cnt != RCT_CW'(RCT_CUTOFF))
      rct_nxt = rct_cnt + 1'b1;

    apt_nxt = (win_cnt == '0) ? APT_CW'(1) : apt_cnt + APT_CW'(sample == ref_bit);

    rct_hit  = sample_valid && !clr && (rct_nxt == RCT_CW'(RCT_CUTOFF));
    apt_hit  = sample_valid && !clr && (apt_nxt >= APT_CW'(APT_CUTOFF));
    fail_evt = rct_hit | apt_hit;
  end

  // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rct_cnt  <= '0;
      last_bit <= 1'b0;
      win_cnt  <= '0;
      ref_bit  <= 1'b0;
      apt_cnt  <= '0;
      rct_fail <= 1'b0;
      apt_fail <= 1'b0;
    end else if (clr) begin
      rct_cnt  <= '0;
      last_bit <= 1'b0;
      win_cnt  <= '0;
      ref_bit  <= 1'b0;
      apt_cnt  <= '0;
      rct_fail <= 1'b0;
      apt_fail <= 1'b0;
    end else if (sample_valid) begin
      rct_cnt  <= rct_nxt;
      last_bit <= sample;
      apt_cnt  <= apt_nxt;
      if (win_cnt == '0) ref_bit <= sample;
      win_cnt  <= (win_cnt == APT_WW'(APT_WIN - 1)) ? '0 : win_cnt + 1'b1;
      if (rct_hit) rct_fail <= 1'b1;
      if (apt_hit) apt_fail <= 1'b1;
    end
  end

endmodule

// File: rtl/rng_postproc.sv
// TRNG post-processor: seeds an LFSR and a hybrid rule-90/150 CASR, whitens
// their combined output into words and halts on raw-stream health failures.
module rng_postproc
  import rng_pkg::*;
#(
  parameter int                LFSR_W     = LFSR_W_DEF,
  parameter logic [LFSR_W-1:0] LFSR_TAPS  = LFSR_TAPS_DEF,
  parameter int                CASR_W     = CASR_W_DEF,
  parameter int                CASR_150   = CASR_150_DEF,
  parameter int                WORD_W     = WORD_W_DEF,
  parameter int                INIT_BITS  = INIT_BITS_DEF,
  parameter int                RCT_CUTOFF = RCT_CUTOFF_DEF,
  parameter int                APT_WIN    = APT_WIN_DEF,
  parameter int                APT_CUTOFF = APT_CUTOFF_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_raw_bit,
  input  logic                     i_raw_valid,
  input  logic                     i_en,
  input  logic                     i_ptb_en,
  input  logic                     i_use_seed,
  input  logic [LFSR_W+CASR_W-1:0] i_seed,
  input  logic                     i_hlth_clr,
  output logic [WORD_W-1:0]        o_word,
  output logic                     o_word_valid,
  input  logic                     i_word_ready,
  output logic                     o_initdone,
  output logic                     o_rct_fail,
  output logic                     o_apt_fail,
  output logic [LFSR_W+CASR_W-1:0] o_state
);

  localparam int ICW = $clog2(INIT_BITS + 1);
  localparam int BCW = $clog2(WORD_W);
  localparam logic [CASR_W-1:0] RULE150_MASK = {{(CASR_W-1){1'b0}}, 1'b1} << CASR_150;

  logic [1:0]        state;
  logic [LFSR_W-1:0] lfsr, lfsr_step;
  logic [CASR_W-1:0] casr, casr_step;
  logic [CASR_W+1:0] casr_pad;
  logic [ICW-1:0]    init_cnt;
  logic [WORD_W-1:0] acc, word_q;
  logic [BCW-1:0]    bit_cnt;
  logic              acc_full, word_valid, use_seed_q;
  logic              p, lfsr_fb, out_bit, consume, fail_evt, fail_now, reseed;

  rng_hlth #(
    .RCT_CUTOFF (RCT_CUTOFF),
    .APT_WIN    (APT_WIN),
    .APT_CUTOFF (APT_CUTOFF)
  ) u_hlth (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample       (i_raw_bit),
    .sample_valid (i_raw_valid),
    .clr          (i_hlth_clr),
    .rct_fail     (o_rct_fail),
    .apt_fail     (o_apt_fail),
    .fail_evt     (fail_evt)
  );

  // The padded copy supplies p as the missing neighbour at both CASR ends.
  always_comb begin
    p         = i_raw_bit & i_raw_valid & i_ptb_en;
    lfsr_fb   = ~^(lfsr & LFSR_TAPS) ^ p;
    lfsr_step = {lfsr[LFSR_W-2:0], lfsr_fb};
    casr_pad  = {p, casr, p};
    casr_step = casr_pad[CASR_W+1:2] ^ casr_pad[CASR_W-1:0] ^ (casr & RULE150_MASK);
    out_bit   = lfsr[LFSR_W-1] ^ casr[CASR_W-1];
    consume   = word_valid & i_word_ready;
    fail_now  = fail_evt | o_rct_fail | o_apt_fail;
    reseed    = i_use_seed & ~use_seed_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_SEED;
      lfsr       <= '0;
      casr       <= '0;
      init_cnt   <= '0;
      acc        <= '0;
      bit_cnt    <= '0;
      acc_full   <= 1'b0;
      word_q     <= '0;
      word_valid <= 1'b0;
      use_seed_q <= 1'b0;
    end else begin
      use_seed_q <= i_use_seed;
      if (consume) word_valid <= 1'b0;
      if (state == ST_FAIL) begin
        if (i_hlth_clr) state <= ST_SEED;
      end else if (fail_now && !i_hlth_clr) begin
        state      <= ST_FAIL;
        word_valid <= 1'b0;
        acc        <= '0;
        bit_cnt    <= '0;
        acc_full   <= 1'b0;
        init_cnt   <= '0;
      end else if (state == ST_SEED) begin
        if (i_use_seed) begin
          {casr, lfsr} <= i_seed;
          state        <= ST_RUN;
        end else if (i_raw_valid) begin
          lfsr     <= {lfsr[LFSR_W-2:0], i_raw_bit};
          casr     <= {casr[CASR_W-2:0], lfsr[LFSR_W-1]};
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == ICW'(INIT_BITS - 1)) state <= ST_RUN;
        end
      end else if (reseed) begin
        // Reload discards the partial accumulator but leaves a presented word alone.
        {casr, lfsr} <= i_seed;
        acc          <= '0;
        bit_cnt      <= '0;
        acc_full     <= 1'b0;
      end else begin
        if (i_en) begin
          lfsr <= lfsr_step;
          casr <= casr_step;
        end
        if (acc_full) begin
          if (!word_valid || consume) begin
            word_q     <= acc;
            word_valid <= 1'b1;
            acc_full   <= 1'b0;
          end
        end else if (i_en) begin
          acc <= {acc[WORD_W-2:0], out_bit};
          if (bit_cnt == BCW'(WORD_W - 1)) begin
            bit_cnt <= '0;
            if (!word_valid || consume) begin
              word_q     <= {acc[WORD_W-2:0], out_bit};
              word_valid <= 1'b1;
            end else begin
              acc_full <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign o_word       = word_q;
  assign o_word_valid = word_valid;
  assign o_initdone   = (state == ST_RUN);
  assign o_state      = {casr, lfsr};

endmodule
